// File: rtl/debounce_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank_if
//  Description : Pin-side bundle of the debounce bank: raw levels in,
//                debounced level and event pulses out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debounce_bank_if #(
    parameter int N = 5
);
    logic [N-1:0] din;
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] hold;

    modport master (output din, input dout, input rise, input fall, input hold);
    modport slave  (input din, output dout, output rise, output fall, output hold);
endinterface
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : N independent button debouncers, each with a 2-FF
//                synchroniser, stability filter, press/release pulses and a
//                one-shot long-hold pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int N          = 5,
    parameter int STABLE     = 20000,
    parameter int CNT_W      = 16,
    parameter int HOLD       = 50000000,
    parameter int HOLD_W     = 26,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debounce_bank_if.slave        bus
);

    localparam logic [CNT_W-1:0] c_stable = CNT_W'(STABLE);
    localparam logic             c_inv    = (ACTIVE_LOW != 0);

    logic [N-1:0] w_dout;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    logic [N-1:0] w_hold;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic             r_s1;
            logic             r_s2;
            logic             r_q;
            logic             r_dout;
            logic             r_rise;
            logic             r_fall;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_q    <= 1'b0;
                    r_cnt  <= '0;
                    r_dout <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_s1 <= bus.din[i] ^ c_inv;
                    r_s2 <= r_s1;
                    r_q  <= r_s2;
                    // Any change restarts the run; the count saturates so it never wraps.
                    if (r_s2 != r_q) begin
                        r_cnt <= '0;
                    end else if (r_cnt < c_stable) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if ((r_cnt == c_stable) && (r_q != r_dout)) begin
                        r_dout <= r_q;
                        r_rise <= r_q;
                        r_fall <= ~r_q;
                    end else begin
                        r_rise <= 1'b0;
                        r_fall <= 1'b0;
                    end
                end
            end

            assign w_dout[i] = r_dout;
            assign w_rise[i] = r_rise;
            assign w_fall[i] = r_fall;

            if (HOLD > 0) begin : g_hold
                localparam logic [HOLD_W-1:0] c_hold    = HOLD_W'(HOLD);
                localparam logic [HOLD_W-1:0] c_hold_m1 = HOLD_W'(HOLD - 1);

                logic [HOLD_W-1:0] r_hcnt;
                logic              r_hold;

                // Saturating at HOLD means the match on HOLD-1 happens once per press.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_hcnt <= '0;
                        r_hold <= 1'b0;
                    end else begin
                        if (!r_dout) begin
                            r_hcnt <= '0;
                        end else if (r_hcnt < c_hold) begin
                            r_hcnt <= r_hcnt + HOLD_W'(1);
                        end
                        r_hold <= r_dout && (r_hcnt == c_hold_m1);
                    end
                end

                assign w_hold[i] = r_hold;
            end else begin : g_no_hold
                assign w_hold[i] = 1'b0;
            end
        end
    endgenerate

    assign bus.dout = w_dout;
    assign bus.rise = w_rise;
    assign bus.fall = w_fall;
    assign bus.hold = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_bank
//  Description : Bench for debounce_bank: an active-high bank with hold and an
//                active-low bank without hold, against a sample-window model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int STB = 4;
    localparam int HA  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debounce_bank_if #(.N(2)) ifa ();
    debounce_bank_if #(.N(2)) ifb ();

    debounce_bank #(.N(2), .STABLE(STB), .CNT_W(4), .HOLD(HA), .HOLD_W(5), .ACTIVE_LOW(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    debounce_bank #(.N(2), .STABLE(STB), .CNT_W(4), .HOLD(0), .HOLD_W(5), .ACTIVE_LOW(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    // Reference: a level is accepted once STB+1 consecutive synchronised samples
    // (pin delayed 3 edges) agree and the run started after the last reset.
    logic [1:0] md [2];
    logic [1:0] mr [2];
    logic [1:0] mf [2];
    logic [1:0] mh [2];
    bit         hist  [2][2][8];
    int         since [2];
    longint     cyc = 0;
    longint     trise [2][2];

    always @(posedge clk) begin
        logic [1:0] dv;
        bit         p, old, v, same;
        int         hl;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            dv = (d == 0) ? ifa.din : ifb.din;
            hl = (d == 0) ? HA : 0;
            for (int c = 0; c < 2; c++) begin
                if (!rst_n) begin
                    for (int j = 0; j < 8; j++) hist[d][c][j] = 1'b0;
                    md[d][c] = 1'b0;
                    mr[d][c] = 1'b0;
                    mf[d][c] = 1'b0;
                    mh[d][c] = 1'b0;
                end else begin
                    p   = dv[c] ^ (d == 1);
                    old = md[d][c];
                    mr[d][c] = 1'b0;
                    mf[d][c] = 1'b0;
                    mh[d][c] = (hl > 0) && old && ((cyc - trise[d][c]) == longint'(hl));
                    if (since[d] + 1 >= STB + 1) begin
                        v    = hist[d][c][2];
                        same = 1'b1;
                        for (int j = 3; j <= 2 + STB; j++)
                            if (hist[d][c][j] != v) same = 1'b0;
                        if (same && (v != old)) begin
                            md[d][c] = v;
                            mr[d][c] = v;
                            mf[d][c] = !v;
                            if (v) trise[d][c] = cyc;
                        end
                    end
                    for (int j = 7; j > 0; j--) hist[d][c][j] = hist[d][c][j-1];
                    hist[d][c][0] = p;
                end
            end
            since[d] = rst_n ? since[d] + 1 : 0;
        end
    end

    wire [7:0] got_a = {ifa.dout, ifa.rise, ifa.fall, ifa.hold};
    wire [7:0] got_b = {ifb.dout, ifb.rise, ifb.fall, ifb.hold};
    wire [7:0] exp_a = {md[0], mr[0], mf[0], mh[0]};
    wire [7:0] exp_b = {md[1], mr[1], mf[1], mh[1]};

    task automatic test_reset();
        rst_n   = 1'b0;
        ifa.din = 2'b00;
        ifb.din = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if (got_a !== 8'h00) begin errors++; $display("FAIL reset_a got=%b exp=%b", got_a, 8'h00); end
        checks++;
        if (got_b !== 8'h00) begin errors++; $display("FAIL reset_b got=%b exp=%b", got_b, 8'h00); end
        rst_n = 1'b1;
    endtask

    task automatic test_press();
        ifa.din = 2'b01;
        for (int e = 0; e < 13; e++) begin
            @(negedge clk);
            checks++;
            if ({ifa.dout[0], ifa.rise[0]} !== {(e >= 7), (e == 7)}) begin
                errors++; $display("FAIL press_ch0 e=%0d got=%b exp=%b", e, {ifa.dout[0], ifa.rise[0]}, {(e >= 7), (e == 7)});
            end
            checks++;
            if ({ifa.dout[1], ifa.rise[1], ifa.fall[1]} !== 3'b000) begin
                errors++; $display("FAIL press_ch1_quiet e=%0d got=%b exp=000", e, {ifa.dout[1], ifa.rise[1], ifa.fall[1]});
            end
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL press_model_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
        end
        ifa.din = 2'b00;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            checks++;
            if ({ifa.dout[0], ifa.fall[0]} !== {(e < 7), (e == 7)}) begin
                errors++; $display("FAIL release_ch0 e=%0d got=%b exp=%b", e, {ifa.dout[0], ifa.fall[0]}, {(e < 7), (e == 7)});
            end
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL release_model_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
        end
    endtask

    task automatic test_glitch();
        ifa.din[0] = 1'b1;
        for (int e = 0; e < 16; e++) begin
            if (e == 4) ifa.din[0] = 1'b0;
            @(negedge clk);
            checks++;
            if ({ifa.dout[0], ifa.rise[0], ifa.fall[0]} !== 3'b000) begin
                errors++; $display("FAIL glitch4 e=%0d got=%b exp=000", e, {ifa.dout[0], ifa.rise[0], ifa.fall[0]});
            end
        end
        ifa.din[0] = 1'b1;
        for (int e = 0; e < 16; e++) begin
            if (e == 5) ifa.din[0] = 1'b0;
            @(negedge clk);
            checks++;
            if ({ifa.dout[0], ifa.rise[0], ifa.fall[0]} !== {(e >= 7 && e < 12), (e == 7), (e == 12)}) begin
                errors++; $display("FAIL pulse5 e=%0d got=%b exp=%b", e, {ifa.dout[0], ifa.rise[0], ifa.fall[0]},
                                   {(e >= 7 && e < 12), (e == 7), (e == 12)});
            end
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL pulse5_model_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
        end
    endtask

    task automatic test_hold();
        ifa.din[1] = 1'b1;
        for (int e = 0; e < 46; e++) begin
            if (e == 30) ifa.din[1] = 1'b0;
            @(negedge clk);
            checks++;
            if ({ifa.rise[1], ifa.hold[1], ifa.fall[1]} !== {(e == 7), (e == 17), (e == 37)}) begin
                errors++; $display("FAIL hold_long e=%0d got=%b exp=%b", e, {ifa.rise[1], ifa.hold[1], ifa.fall[1]},
                                   {(e == 7), (e == 17), (e == 37)});
            end
        end
        ifa.din[1] = 1'b1;
        for (int e = 0; e < 26; e++) begin
            if (e == 8) ifa.din[1] = 1'b0;
            @(negedge clk);
            checks++;
            if ({ifa.rise[1], ifa.hold[1], ifa.fall[1]} !== {(e == 7), 1'b0, (e == 15)}) begin
                errors++; $display("FAIL hold_short e=%0d got=%b exp=%b", e, {ifa.rise[1], ifa.hold[1], ifa.fall[1]},
                                   {(e == 7), 1'b0, (e == 15)});
            end
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL hold_model_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
        end
    endtask

    task automatic test_active_low();
        checks++;
        if (got_b !== 8'h00) begin errors++; $display("FAIL al_idle got=%b exp=%b", got_b, 8'h00); end
        ifb.din[0] = 1'b0;
        for (int e = 0; e < 110; e++) begin
            if (e == 100) ifb.din[0] = 1'b1;
            @(negedge clk);
            checks++;
            if ({ifb.dout[0], ifb.rise[0], ifb.fall[0], ifb.hold[0]} !== {(e >= 7 && e < 107), (e == 7), (e == 107), 1'b0}) begin
                errors++; $display("FAIL al_press e=%0d got=%b exp=%b", e, {ifb.dout[0], ifb.rise[0], ifb.fall[0], ifb.hold[0]},
                                   {(e >= 7 && e < 107), (e == 7), (e == 107), 1'b0});
            end
            checks++;
            if (got_b !== exp_b) begin errors++; $display("FAIL al_model_b e=%0d got=%b exp=%b", e, got_b, exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        ifa.din = 2'b01;
        for (int e = 0; e < 33; e++) begin
            if (e == 12) ifa.din[0] = 1'b0;
            if (e == 13) ifa.din[0] = 1'b1;
            if (e == 19) rst_n = 1'b0;
            if (e == 20) rst_n = 1'b1;
            @(negedge clk);
            if (e == 19) begin
                checks++;
                if (got_a !== 8'h00) begin errors++; $display("FAIL midreset_clear got=%b exp=%b", got_a, 8'h00); end
            end else if (e >= 20) begin
                checks++;
                if ({ifa.dout[0], ifa.rise[0]} !== {(e >= 27), (e == 27)}) begin
                    errors++; $display("FAIL midreset_rerise e=%0d got=%b exp=%b", e, {ifa.dout[0], ifa.rise[0]}, {(e >= 27), (e == 27)});
                end
            end else begin
                checks++;
                if (ifa.dout[0] !== (e >= 7)) begin
                    errors++; $display("FAIL midreset_pre e=%0d got=%b exp=%b", e, ifa.dout[0], (e >= 7));
                end
            end
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL midreset_model_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
        end
    endtask

    task automatic test_random();
        int seg = 0;
        for (int e = 0; e < 800; e++) begin
            if (seg == 0) begin
                ifa.din = 2'($urandom);
                ifb.din = 2'($urandom);
                seg     = $urandom_range(1, 24);
            end
            seg--;
            rst_n = ($urandom_range(0, 119) != 0);
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL random_a e=%0d got=%b exp=%b", e, got_a, exp_a); end
            checks++;
            if (got_b !== exp_b) begin errors++; $display("FAIL random_b e=%0d got=%b exp=%b", e, got_b, exp_b); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        ifa.din = 2'b00;
        ifb.din = 2'b11;
        @(negedge clk);
        test_reset();
        test_press();
        test_glitch();
        test_hold();
        test_active_low();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
